// File: rtl/dice_roll_engine.sv
// Dice roll engine: N dice of S sides drawn from a free-running Galois LFSR.
// The dice tumble while the button is held, latch on release, and an optional craps FSM tracks the point.
module dice_roll_engine #(
  parameter int                NUM_DICE = 2,
  parameter int                SIDES    = 6,
  parameter int                DIE_W    = 4,
  parameter int                TICK_DIV = 2500000,
  parameter int                LFSR_W   = 32,
  parameter logic [LFSR_W-1:0] TAPS     = 32'h80200003,
  parameter logic [LFSR_W-1:0] SEED     = 32'hACE1_1234,
  parameter int                MODE     = 1,
  localparam int               SUM_W    = $clog2(NUM_DICE*SIDES+1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rb,
  output logic [NUM_DICE*DIE_W-1:0] dice,
  output logic [SUM_W-1:0]          sum,
  output logic [SUM_W-1:0]          point,
  output logic                      roll_valid,
  output logic                      rolling,
  output logic                      win,
  output logic                      lose,
  output logic [2:0]                state_dbg
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ROLL   = 3'd1,
    EVAL   = 3'd2,
    RESULT = 3'd3,
    OVER   = 3'd4
  } state_t;

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  function automatic logic [NUM_DICE*DIE_W-1:0] all_ones_dice();
    logic [NUM_DICE*DIE_W-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_DICE; i++) v[i*DIE_W +: DIE_W] = DIE_W'(1);
    return v;
  endfunction

  localparam logic [NUM_DICE*DIE_W-1:0] DICE_ONES = all_ones_dice();

  state_t                    state, state_nxt;
  logic [LFSR_W-1:0]         lfsr, lfsr_nxt;
  logic                      rb_q;
  logic                      armed;
  logic [CNT_W-1:0]          cnt;
  logic [NUM_DICE*DIE_W-1:0] dice_r;
  logic [SUM_W-1:0]          sum_r;
  logic [SUM_W-1:0]          point_r;
  logic                      win_r, lose_r;

  logic                      press;
  logic [DIE_W-1:0]          samp_die [NUM_DICE];
  logic [NUM_DICE*DIE_W-1:0] samp_dice;
  logic [SUM_W-1:0]          samp_sum;

  logic cnt_clr, cnt_adv, tumble, do_eval, clr_game, set_point, res_win, res_lose;

  // armed stays low while rb has been high since reset, so a held button cannot start a roll.
  assign press = rb & ~rb_q & armed;

  assign lfsr_nxt = (lfsr == '0) ? SEED
                  : ({1'b0, lfsr[LFSR_W-1:1]} ^ (lfsr[0] ? TAPS : '0));

  always_comb begin
    samp_dice = '0;
    samp_sum  = '0;
    for (int i = 0; i < NUM_DICE; i++) begin
      samp_die[i] = DIE_W'((32'(lfsr[i*8 +: 8]) % SIDES) + 1);
      samp_dice[i*DIE_W +: DIE_W] = samp_die[i];
      samp_sum = samp_sum + SUM_W'(samp_die[i]);
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_clr   = 1'b0;
    cnt_adv   = 1'b0;
    tumble    = 1'b0;
    do_eval   = 1'b0;
    clr_game  = 1'b0;
    set_point = 1'b0;
    res_win   = 1'b0;
    res_lose  = 1'b0;
    case (state)
      IDLE: begin
        if (press) begin
          state_nxt = ROLL;
          cnt_clr   = 1'b1;
        end
      end
      ROLL: begin
        cnt_adv = 1'b1;
        tumble  = (cnt == CNT_LAST);
        if (!rb) state_nxt = EVAL;
      end
      EVAL: begin
        do_eval   = 1'b1;
        state_nxt = RESULT;
      end
      RESULT: begin
        state_nxt = IDLE;
        if (MODE != 0) begin
          if (point_r == '0) begin
            if (sum_r == SUM_W'(7) || sum_r == SUM_W'(11)) res_win = 1'b1;
            else if (sum_r == SUM_W'(2) || sum_r == SUM_W'(3) || sum_r == SUM_W'(12)) res_lose = 1'b1;
            else set_point = 1'b1;
          end else begin
            if (sum_r == point_r) res_win = 1'b1;
            else if (sum_r == SUM_W'(7)) res_lose = 1'b1;
          end
          if (res_win || res_lose) state_nxt = OVER;
        end
      end
      OVER: begin
        if (press) begin
          state_nxt = ROLL;
          cnt_clr   = 1'b1;
          clr_game  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      lfsr    <= SEED;
      rb_q    <= 1'b0;
      armed   <= ~rb;
      cnt     <= '0;
      dice_r  <= DICE_ONES;
      sum_r   <= SUM_W'(NUM_DICE);
      point_r <= '0;
      win_r   <= 1'b0;
      lose_r  <= 1'b0;
    end else begin
      state <= state_nxt;
      lfsr  <= lfsr_nxt;
      rb_q  <= rb;
      armed <= armed | ~rb;
      if (cnt_clr)      cnt <= '0;
      else if (cnt_adv) cnt <= (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
      if (tumble || do_eval) dice_r <= samp_dice;
      if (do_eval)           sum_r  <= samp_sum;
      if (clr_game) begin
        win_r   <= 1'b0;
        lose_r  <= 1'b0;
        point_r <= '0;
      end
      if (set_point) point_r <= sum_r;
      if (res_win)   win_r   <= 1'b1;
      if (res_lose)  lose_r  <= 1'b1;
    end
  end

  // win/lose are decided combinationally in RESULT so they line up with roll_valid.
  assign dice       = dice_r;
  assign sum        = sum_r;
  assign point      = point_r;
  assign roll_valid = (state == RESULT);
  assign rolling    = (state == ROLL);
  assign win        = win_r | res_win;
  assign lose       = lose_r | res_lose;
  assign state_dbg  = state;

endmodule

// File: tb/tb_dice_roll_engine.sv
// Directed bench for dice_roll_engine (2 dice, 6 sides, craps, TICK_DIV=4).
// A golden LFSR model picks idle gaps so each table roll lands on its target sum.
module tb_dice_roll_engine;

  localparam logic [31:0] SEED = 32'hACE1_1234;
  localparam logic [31:0] TAPS = 32'h80200003;
  localparam int          TDIV = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rb  = 1'b1;
  logic [7:0] dice;
  logic [3:0] sum, point;
  logic       roll_valid, rolling, win, lose;
  logic [2:0] state_dbg;

  dice_roll_engine #(
    .NUM_DICE(2), .SIDES(6), .DIE_W(4), .TICK_DIV(TDIV),
    .LFSR_W(32), .TAPS(TAPS), .SEED(SEED), .MODE(1)
  ) dut (
    .clk(clk), .rst(rst), .rb(rb), .dice(dice), .sum(sum), .point(point),
    .roll_valid(roll_valid), .rolling(rolling), .win(win), .lose(lose),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] lfsr_step(input logic [31:0] v);
    if (v == 32'h0) return SEED;
    return {1'b0, v[31:1]} ^ (v[0] ? TAPS : 32'h0);
  endfunction

  function automatic logic [7:0] map_dice(input logic [31:0] v);
    logic [7:0] b0, b1;
    b0 = v[7:0];
    b1 = v[15:8];
    return {4'(b1 % 6 + 1), 4'(b0 % 6 + 1)};
  endfunction

  function automatic int sum_of(input logic [7:0] d);
    return int'(d[3:0]) + int'(d[7:4]);
  endfunction

  // Golden LFSR: value held by the DUT register after each edge.
  logic [31:0] m_lfsr;
  always @(posedge clk) begin
    if (rst) m_lfsr <= SEED;
    else     m_lfsr <= lfsr_step(m_lfsr);
  end

  typedef struct {
    int hold;
    int target;
    bit e_win;
    bit e_lose;
    int e_point;
  } roll_vec_t;

  roll_vec_t  tbl [12];
  int         n_vec = 0;
  int         n_bad = 0;
  logic [7:0] exp_dice;
  int         exp_sum;
  int         cur_point;
  bit         in_over;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_dice"}, 32'(dice), 32'h11);
    check({tag, "_sum"}, 32'(sum), 32'd2);
    check({tag, "_point"}, 32'(point), 32'd0);
    check({tag, "_rolling"}, 32'(rolling), 32'd0);
    check({tag, "_valid"}, 32'(roll_valid), 32'd0);
    check({tag, "_win"}, 32'(win), 32'd0);
    check({tag, "_lose"}, 32'(lose), 32'd0);
  endtask

  task automatic do_roll(input int idx, input roll_vec_t rv);
    logic [31:0] w;
    logic [7:0]  fd;
    int          gap;
    bit          found;
    string       t;
    t = $sformatf("r%0d", idx);
    // Search for an idle gap that makes the EVAL-cycle sample hit the target sum.
    w = m_lfsr;
    repeat (rv.hold + 1) w = lfsr_step(w);
    found = 1'b0;
    gap   = 0;
    for (int g = 0; g < 3000 && !found; g++) begin
      if (sum_of(map_dice(w)) == rv.target) begin
        found = 1'b1;
        gap   = g;
      end else begin
        w = lfsr_step(w);
      end
    end
    if (!found) begin
      n_vec++;
      n_bad++;
      $display("FAIL %s_search: no gap found, required sum %0d", t, rv.target);
      return;
    end
    repeat (gap) tick();
    rb = 1'b1;
    tick();
    check({t, "_entry_rolling"}, 32'(rolling), 32'd1);
    check({t, "_entry_win"}, 32'(win), 32'd0);
    check({t, "_entry_lose"}, 32'(lose), 32'd0);
    check({t, "_entry_point"}, 32'(point), in_over ? 32'd0 : 32'(cur_point));
    check({t, "_entry_dice"}, 32'(dice), 32'(exp_dice));
    for (int j = 0; j < rv.hold; j++) begin
      if (j == rv.hold - 1) rb = 1'b0;
      if (j % TDIV == TDIV - 1) exp_dice = map_dice(m_lfsr);
      tick();
      check($sformatf("%s_tumble%0d_dice", t, j), 32'(dice), 32'(exp_dice));
      check($sformatf("%s_tumble%0d_sum", t, j), 32'(sum), 32'(exp_sum));
      check($sformatf("%s_tumble%0d_rolling", t, j), 32'(rolling), (j < rv.hold - 1) ? 32'd1 : 32'd0);
      check($sformatf("%s_tumble%0d_valid", t, j), 32'(roll_valid), 32'd0);
    end
    fd = map_dice(m_lfsr);
    tick();
    check({t, "_res_valid"}, 32'(roll_valid), 32'd1);
    check({t, "_res_dice"}, 32'(dice), 32'(fd));
    check({t, "_res_sum"}, 32'(sum), 32'(rv.target));
    check({t, "_res_win"}, 32'(win), 32'(rv.e_win));
    check({t, "_res_lose"}, 32'(lose), 32'(rv.e_lose));
    check({t, "_die0_range"}, 32'(dice[3:0] >= 4'd1 && dice[3:0] <= 4'd6), 32'd1);
    check({t, "_die1_range"}, 32'(dice[7:4] >= 4'd1 && dice[7:4] <= 4'd6), 32'd1);
    exp_dice  = fd;
    exp_sum   = rv.target;
    cur_point = rv.e_point;
    in_over   = rv.e_win | rv.e_lose;
    tick();
    check({t, "_post_valid"}, 32'(roll_valid), 32'd0);
    check({t, "_post_point"}, 32'(point), 32'(rv.e_point));
    check({t, "_post_win"}, 32'(win), 32'(rv.e_win));
    check({t, "_post_lose"}, 32'(lose), 32'(rv.e_lose));
    if (in_over) begin
      repeat (2) begin
        tick();
        check({t, "_over_win"}, 32'(win), 32'(rv.e_win));
        check({t, "_over_lose"}, 32'(lose), 32'(rv.e_lose));
        check({t, "_over_dice"}, 32'(dice), 32'(exp_dice));
        check({t, "_over_sum"}, 32'(sum), 32'(exp_sum));
        check({t, "_over_point"}, 32'(point), 32'(cur_point));
      end
    end
  endtask

  initial begin
    // hold, target, win, lose, point after the roll
    tbl[0]  = '{2,  7,  1'b1, 1'b0, 0};
    tbl[1]  = '{13, 12, 1'b0, 1'b1, 0};
    tbl[2]  = '{3,  6,  1'b0, 1'b0, 6};
    tbl[3]  = '{5,  8,  1'b0, 1'b0, 6};
    tbl[4]  = '{6,  6,  1'b1, 1'b0, 6};
    tbl[5]  = '{6,  4,  1'b0, 1'b0, 4};
    tbl[6]  = '{2,  7,  1'b0, 1'b1, 4};
    tbl[7]  = '{3,  11, 1'b1, 1'b0, 0};
    tbl[8]  = '{7,  2,  1'b0, 1'b1, 0};
    tbl[9]  = '{2,  3,  1'b0, 1'b1, 0};
    tbl[10] = '{9,  5,  1'b0, 1'b0, 5};
    tbl[11] = '{3,  7,  1'b1, 1'b0, 0};

    exp_dice  = 8'h11;
    exp_sum   = 2;
    cur_point = 0;
    in_over   = 1'b0;

    // Reset with the button held; release must not start a roll.
    rst = 1'b1;
    rb  = 1'b1;
    repeat (3) tick();
    check_reset_outputs("rst_in");
    rst = 1'b0;
    tick();
    check_reset_outputs("rst_rel");
    repeat (4) begin
      tick();
      check("held_no_roll", 32'(rolling), 32'd0);
    end
    rb = 1'b0;
    tick();
    check("released_idle", 32'(rolling), 32'd0);

    for (int i = 0; i < 11; i++) do_roll(i, tbl[i]);

    // Abort a roll in progress with reset; the LFSR restart is seen through the next roll.
    rb = 1'b1;
    tick();
    check("abort_entry_rolling", 32'(rolling), 32'd1);
    repeat (5) tick();
    rst = 1'b1;
    tick();
    check_reset_outputs("abort");
    rst = 1'b0;
    rb  = 1'b0;
    tick();
    check("abort_idle", 32'(rolling), 32'd0);
    exp_dice  = 8'h11;
    exp_sum   = 2;
    cur_point = 0;
    in_over   = 1'b0;
    do_roll(11, tbl[11]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
